// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage
//   Instruction decode stage: register file, sign extension, main control
//   decode, load-use hazard detection and the ID/EX pipeline register.
//
//   Ports
//     clk, reset            sole clock; asynchronous active-high reset
//     inValid               IF/ID holds a live instruction
//     instruction           32-bit instruction word from IF/ID
//     pcMore4Input          PC+4 from IF/ID
//     regWriteIn, writeRegister, writeData
//                           writeback port into the register file
//     flush                 EX resolved a taken branch/jump
//     exMemRead, exRt       load-in-EX information for hazard detection
//     stall                 combinational; IF holds PC and IF/ID
//     outValid ... regWriteOut
//                           registered ID/EX fields and control
//
//   Configuration
//     DECODE_HAZARD_STAGE_BYPASS_EN  when defined, a read of the register being
//                                    written this cycle returns writeData
//                                    (write-through); otherwise the stored value.
module decode_hazard_stage #(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 32,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inValid,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pcMore4Input,
   input  logic              regWriteIn,
   input  logic [AW-1:0]     writeRegister,
   input  logic [DATA_W-1:0] writeData,
   input  logic              flush,
   input  logic              exMemRead,
   input  logic [AW-1:0]     exRt,
   output logic              stall,
   output logic              outValid,
   output logic [DATA_W-1:0] readRegister0,
   output logic [DATA_W-1:0] readRegister1,
   output logic [DATA_W-1:0] immediateExtended,
   output logic [DATA_W-1:0] pcMore4Output,
   output logic [AW-1:0]     addressRegisterRs,
   output logic [AW-1:0]     addressRegisterRt,
   output logic [AW-1:0]     addressRegisterRd,
   output logic              regDst,
   output logic              jump,
   output logic [1:0]        branch,
   output logic              memRead,
   output logic              memToReg,
   output logic [3:0]        aluOp,
   output logic              memWrite,
   output logic              aluSrc,
   output logic              regWriteOut
);

   typedef struct packed {
      logic       reg_dst;
      logic       jump;
      logic [1:0] branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [3:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   // ---------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------
   logic [5:0]        opcode;
   logic [AW-1:0]     rs_idx;
   logic [AW-1:0]     rt_idx;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] imm_ext;

   assign opcode  = instruction[31:26];
   assign rs_idx  = AW'(instruction[25:21]);
   assign rt_idx  = AW'(instruction[20:16]);
   assign rd_idx  = AW'(instruction[15:11]);
   assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

   // ---------------------------------------------------------------
   // Register file (entry 0 is never written, so it stays zero)
   // ---------------------------------------------------------------
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (regWriteIn && (writeRegister != '0)) begin
         regs_q[writeRegister] <= writeData;
      end
   end

   logic [DATA_W-1:0] rd0_val;
   logic [DATA_W-1:0] rd1_val;

   always_comb begin
      rd0_val = '0;
      rd1_val = '0;
      if ((rs_idx != '0) && (int'(rs_idx) < NUM_REGS)) rd0_val = regs_q[rs_idx];
      if ((rt_idx != '0) && (int'(rt_idx) < NUM_REGS)) rd1_val = regs_q[rt_idx];
`ifdef DECODE_HAZARD_STAGE_BYPASS_EN
      if (regWriteIn && (writeRegister != '0)) begin
         if (writeRegister == rs_idx) rd0_val = writeData;
         if (writeRegister == rt_idx) rd1_val = writeData;
      end
`endif
   end

   // ---------------------------------------------------------------
   // Main control decode
   // ---------------------------------------------------------------
   ctrl_t dec_ctrl;
   logic  uses_rt;

   always_comb begin
      dec_ctrl = '0;
      uses_rt  = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            dec_ctrl.reg_dst   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = 4'b1111;
            uses_rt            = 1'b1;
         end
         OP_LW: begin
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.alu_op     = 4'b0010;
         end
         OP_SW: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_op    = 4'b0010;
            uses_rt            = 1'b1;
         end
         OP_ADDI: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = 4'b0010;
         end
         OP_BEQ: begin
            dec_ctrl.branch = 2'b01;
            dec_ctrl.alu_op = 4'b0110;
            uses_rt         = 1'b1;
         end
         OP_BNE: begin
            dec_ctrl.branch = 2'b10;
            dec_ctrl.alu_op = 4'b0110;
            uses_rt         = 1'b1;
         end
         OP_J: begin
            dec_ctrl.jump = 1'b1;
         end
         default: begin
            dec_ctrl = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Load-use hazard: flush wins, and reset forces stall low
   // ---------------------------------------------------------------
   logic stall_c;

   assign stall_c = !reset && inValid && exMemRead && (exRt != '0) && !flush &&
                    ((exRt == rs_idx) || ((exRt == rt_idx) && uses_rt));
   assign stall   = stall_c;

   // ---------------------------------------------------------------
   // ID/EX register: data always loads, control is zeroed on a bubble
   // ---------------------------------------------------------------
   logic              bubble;
   ctrl_t             ctrl_d,   ctrl_q;
   logic              valid_d,  valid_q;
   logic [DATA_W-1:0] rd0_d,    rd0_q;
   logic [DATA_W-1:0] rd1_d,    rd1_q;
   logic [DATA_W-1:0] imm_d,    imm_q;
   logic [DATA_W-1:0] pc4_d,    pc4_q;
   logic [AW-1:0]     rs_d,     rs_q;
   logic [AW-1:0]     rt_d,     rt_q;
   logic [AW-1:0]     rd_d,     rd_q;

   assign bubble = flush || stall_c || !inValid;

   always_comb begin
      valid_d = !bubble;
      ctrl_d  = bubble ? ctrl_t'('0) : dec_ctrl;
      rd0_d   = rd0_val;
      rd1_d   = rd1_val;
      imm_d   = imm_ext;
      pc4_d   = pcMore4Input;
      rs_d    = rs_idx;
      rt_d    = rt_idx;
      rd_d    = rd_idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         imm_q   <= imm_d;
         pc4_q   <= pc4_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
      end
   end

   assign outValid          = valid_q;
   assign readRegister0     = rd0_q;
   assign readRegister1     = rd1_q;
   assign immediateExtended = imm_q;
   assign pcMore4Output     = pc4_q;
   assign addressRegisterRs = rs_q;
   assign addressRegisterRt = rt_q;
   assign addressRegisterRd = rd_q;
   assign regDst            = ctrl_q.reg_dst;
   assign jump              = ctrl_q.jump;
   assign branch            = ctrl_q.branch;
   assign memRead           = ctrl_q.mem_read;
   assign memToReg          = ctrl_q.mem_to_reg;
   assign aluOp             = ctrl_q.alu_op;
   assign memWrite          = ctrl_q.mem_write;
   assign aluSrc            = ctrl_q.alu_src;
   assign regWriteOut       = ctrl_q.reg_write;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb_decode_hazard_stage
//   Directed bench for decode_hazard_stage with hand-computed expectations.
//   Control outputs are compared as one 13-bit vector:
//   {regDst, jump, branch[1:0], memRead, memToReg, aluOp[3:0], memWrite, aluSrc, regWriteOut}
module tb_decode_hazard_stage;

   localparam int DATA_W = 32;
   localparam int AW     = 5;

   // Hand-encoded control vectors
   localparam logic [12:0] C_NONE = 13'h0000;
   localparam logic [12:0] C_R    = 13'h1079;
   localparam logic [12:0] C_LW   = 13'h0193;
   localparam logic [12:0] C_SW   = 13'h0016;
   localparam logic [12:0] C_ADDI = 13'h0013;
   localparam logic [12:0] C_BEQ  = 13'h0230;
   localparam logic [12:0] C_BNE  = 13'h0430;
   localparam logic [12:0] C_J    = 13'h0800;

   logic              clk = 1'b0;
   logic              reset;
   logic              inValid;
   logic [31:0]       instruction;
   logic [DATA_W-1:0] pcMore4Input;
   logic              regWriteIn;
   logic [AW-1:0]     writeRegister;
   logic [DATA_W-1:0] writeData;
   logic              flush;
   logic              exMemRead;
   logic [AW-1:0]     exRt;
   logic              stall;
   logic              outValid;
   logic [DATA_W-1:0] readRegister0;
   logic [DATA_W-1:0] readRegister1;
   logic [DATA_W-1:0] immediateExtended;
   logic [DATA_W-1:0] pcMore4Output;
   logic [AW-1:0]     addressRegisterRs;
   logic [AW-1:0]     addressRegisterRt;
   logic [AW-1:0]     addressRegisterRd;
   logic              regDst;
   logic              jump;
   logic [1:0]        branch;
   logic              memRead;
   logic              memToReg;
   logic [3:0]        aluOp;
   logic              memWrite;
   logic              aluSrc;
   logic              regWriteOut;

   int unsigned n_compared   = 0;
   int unsigned n_mismatched = 0;

   decode_hazard_stage #(.DATA_W(DATA_W), .NUM_REGS(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .inValid           (inValid),
      .instruction       (instruction),
      .pcMore4Input      (pcMore4Input),
      .regWriteIn        (regWriteIn),
      .writeRegister     (writeRegister),
      .writeData         (writeData),
      .flush             (flush),
      .exMemRead         (exMemRead),
      .exRt              (exRt),
      .stall             (stall),
      .outValid          (outValid),
      .readRegister0     (readRegister0),
      .readRegister1     (readRegister1),
      .immediateExtended (immediateExtended),
      .pcMore4Output     (pcMore4Output),
      .addressRegisterRs (addressRegisterRs),
      .addressRegisterRt (addressRegisterRt),
      .addressRegisterRd (addressRegisterRd),
      .regDst            (regDst),
      .jump              (jump),
      .branch            (branch),
      .memRead           (memRead),
      .memToReg          (memToReg),
      .aluOp             (aluOp),
      .memWrite          (memWrite),
      .aluSrc            (aluSrc),
      .regWriteOut       (regWriteOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] ctrl_vec();
      return {regDst, jump, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWriteOut};
   endfunction

   // Advance one clock and land 1 ns after the edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inValid       = 1'b0;
      instruction   = 32'h0;
      pcMore4Input  = 32'h0;
      regWriteIn    = 1'b0;
      writeRegister = '0;
      writeData     = '0;
      flush         = 1'b0;
      exMemRead     = 1'b0;
      exRt          = '0;
   endtask

   logic [31:0] old_r7;
   logic [31:0] exp_bypass;

   initial begin
      idle_inputs();
      reset = 1'b1;
      // A hazard-looking input while reset is high must not raise stall
      inValid     = 1'b1;
      instruction = 32'h00A61820;   // add r3,r5,r6
      exMemRead   = 1'b1;
      exRt        = 5'd5;
      #12;
      check("stall_in_reset", stall, 1'b0);
      check("rst_outValid", outValid, 1'b0);
      check("rst_ctrl", ctrl_vec(), C_NONE);
      check("rst_rd0", readRegister0, 32'h0);
      check("rst_pc4", pcMore4Output, 32'h0);

      // Release between edges, then write r5 = 0xAA
      idle_inputs();
      #2 reset = 1'b0;
      @(posedge clk); #1;
      regWriteIn = 1'b1; writeRegister = 5'd5; writeData = 32'h0000_00AA;
      step();
      check("bubble_invalid", outValid, 1'b0);
      check("bubble_invalid_ctrl", ctrl_vec(), C_NONE);

      // add r3,r5,r0
      regWriteIn   = 1'b0;
      inValid      = 1'b1;
      instruction  = 32'h00A01820;
      pcMore4Input = 32'h0000_0104;
      step();
      check("add_rd0", readRegister0, 32'h0000_00AA);
      check("add_rd1", readRegister1, 32'h0);
      check("add_ctrl", ctrl_vec(), C_R);
      check("add_valid", outValid, 1'b1);
      check("add_rd_addr", addressRegisterRd, 5'd3);
      check("add_rs_addr", addressRegisterRs, 5'd5);
      check("add_pc4", pcMore4Output, 32'h0000_0104);

      // Load-use hazard on rs: add r3,r5,r6 with lw r5 in EX
      instruction = 32'h00A61820;
      exMemRead   = 1'b1;
      exRt        = 5'd5;
      #1;
      check("stall_rs", stall, 1'b1);
      step();
      check("stall_bubble_valid", outValid, 1'b0);
      check("stall_bubble_ctrl", ctrl_vec(), C_NONE);
      exMemRead = 1'b0;
      #1;
      check("stall_clear", stall, 1'b0);
      step();
      check("stall_issue_valid", outValid, 1'b1);
      check("stall_issue_ctrl", ctrl_vec(), C_R);

      // Hazard on rt: sw uses rt, lw does not; exRt == 0 never stalls
      exMemRead   = 1'b1;
      exRt        = 5'd5;
      instruction = 32'hAC250000;   // sw r5,0(r1)
      #1;
      check("stall_sw_rt", stall, 1'b1);
      instruction = 32'h8C250000;   // lw r5,0(r1)
      #1;
      check("nostall_lw_rt", stall, 1'b0);
      exRt        = 5'd0;
      instruction = 32'h00001820;   // add r3,r0,r0
      #1;
      check("nostall_exrt0", stall, 1'b0);

      // Flush beats stall
      exRt        = 5'd5;
      instruction = 32'h00A61820;
      flush       = 1'b1;
      #1;
      check("flush_stall", stall, 1'b0);
      step();
      check("flush_valid", outValid, 1'b0);
      check("flush_ctrl", ctrl_vec(), C_NONE);
      flush     = 1'b0;
      exMemRead = 1'b0;

      // Same-cycle write/read of r7
      instruction = 32'h0;
      inValid     = 1'b0;
      regWriteIn = 1'b1; writeRegister = 5'd7; writeData = 32'h0000_1111;
      step();
      old_r7 = 32'h0000_1111;
`ifdef DECODE_HAZARD_STAGE_BYPASS_EN
      exp_bypass = 32'h0000_1234;
`else
      exp_bypass = old_r7;
`endif
      inValid     = 1'b1;
      instruction = 32'h00E01820;   // add r3,r7,r0
      writeData   = 32'h0000_1234;
      step();
      check("wr_rd_r7", readRegister0, exp_bypass);
      regWriteIn = 1'b0;
      step();
      check("r7_after", readRegister0, 32'h0000_1234);

      // Write r0 then read it; lw with negative immediate
      inValid    = 1'b0;
      regWriteIn = 1'b1; writeRegister = 5'd0; writeData = 32'hFFFF_FFFF;
      step();
      regWriteIn  = 1'b0;
      inValid     = 1'b1;
      instruction = 32'h8C048004;   // lw r4,0x8004(r0)
      step();
      check("r0_zero", readRegister0, 32'h0);
      check("lw_imm", immediateExtended, 32'hFFFF_8004);
      check("lw_ctrl", ctrl_vec(), C_LW);
      check("lw_rt_addr", addressRegisterRt, 5'd4);

      instruction = 32'hAC250010;  step(); check("sw_ctrl", ctrl_vec(), C_SW);
      check("sw_imm", immediateExtended, 32'h0000_0010);
      instruction = 32'h20A3FFFF;  step(); check("addi_ctrl", ctrl_vec(), C_ADDI);
      check("addi_rd0", readRegister0, 32'h0000_00AA);
      instruction = 32'h10A60002;  step(); check("beq_ctrl", ctrl_vec(), C_BEQ);
      instruction = 32'h14A60002;  step(); check("bne_ctrl", ctrl_vec(), C_BNE);
      instruction = 32'h08000040;  step(); check("j_ctrl", ctrl_vec(), C_J);
      instruction = 32'hFC000000;  step(); check("nop_ctrl", ctrl_vec(), C_NONE);
      check("nop_valid", outValid, 1'b1);

      // Reset pulsed between edges, while a stall is being requested
      instruction = 32'h00A01820;
      step();
      check("pre_rst_rd0", readRegister0, 32'h0000_00AA);
      exMemRead = 1'b1;
      exRt      = 5'd5;
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", outValid, 1'b0);
      check("async_rst_ctrl", ctrl_vec(), C_NONE);
      check("async_rst_rd0", readRegister0, 32'h0);
      check("async_rst_stall", stall, 1'b0);
      #1 reset = 1'b0;
      exMemRead = 1'b0;
      step();
      check("post_rst_r5", readRegister0, 32'h0);
      check("post_rst_valid", outValid, 1'b1);
      check("post_rst_ctrl", ctrl_vec(), C_R);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_hazard_stage.md
DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width (instruction fixed 32 bits).
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; AW = clog2(NUM_REGS), 5 at default.
REQ-003 SHALL have ports clk in 1 (sole clock) and reset in 1 (asynchronous, active-high).
REQ-004 SHALL have inValid in 1, meaning the IF/ID register holds a live instruction.
REQ-005 SHALL have instruction in 32 and pcMore4Input in DATA_W.
REQ-006 SHALL have regWriteIn in 1, writeRegister in AW and writeData in DATA_W, the writeback port.
REQ-007 SHALL have flush in 1, meaning EX resolved a taken branch or jump.
REQ-008 SHALL have exMemRead in 1 and exRt in AW, describing the instruction currently in EX.
REQ-009 SHALL have stall out 1, combinational, which makes IF hold PC and IF/ID.
REQ-010 SHALL have registered outputs: outValid 1, readRegister0/readRegister1 DATA_W, immediateExtended DATA_W, pcMore4Output DATA_W, addressRegisterRs/Rt/Rd AW.
REQ-011 SHALL have registered control outputs: regDst, jump, branch[1:0], memRead, memToReg, aluOp[3:0], memWrite, aluSrc, regWriteOut.

Function
REQ-012 SHALL hold NUM_REGS x DATA_W registers, written on posedge clk when regWriteIn=1 and writeRegister!=0.
REQ-013 SHALL always read register 0 as 0; writes to register 0 have no effect.
REQ-014 SHALL sign-extend instruction[15:0] to DATA_W.
REQ-015 SHALL decode opcodes as follows (flags not listed are 0):
- 0x00 R-type: regDst, regWriteOut, aluOp=1111.
- 0x23 lw: aluSrc, memRead, memToReg, regWriteOut, aluOp=0010.
- 0x2B sw: aluSrc, memWrite, aluOp=0010.
- 0x08 addi: aluSrc, regWriteOut, aluOp=0010.
- 0x04 beq: branch=01, aluOp=0110.
- 0x05 bne: branch=10, aluOp=0110.
- 0x02 j: jump.
REQ-016 SHALL treat any other opcode as a NOP (all controls 0), with outValid still following inValid.
REQ-017 SHALL define "uses rt" as true for R-type, sw, beq and bne.
REQ-018 SHALL assert stall = inValid & exMemRead & exRt!=0 & !flush & (exRt==rs | (exRt==rt & uses rt)).
REQ-019 SHALL load the ID/EX register every cycle, with latency 1 from IF/ID to outputs.
REQ-020 SHALL load a bubble when flush or stall is 1: outValid=0 and all control outputs 0; data fields still load.
REQ-021 SHALL give flush priority over stall: with flush=1, stall=0 and a bubble is inserted.
REQ-022 SHALL load controls and outValid=1 from decode when inValid=1 and neither flush nor stall is asserted.
REQ-023 SHALL load a bubble when inValid=0.

Reset
REQ-024 SHALL, on reset assertion, immediately clear all register-file entries and all registered outputs to 0, independent of clk.
REQ-025 SHALL drive stall=0 while reset is high.
REQ-026 SHALL resume normal loading on the first posedge after reset deasserts.
REQ-027 SHALL, when reset occurs mid-stall, discard the stalled instruction state, with no stall carried over.

Configuration
REQ-028 SHALL honour macro DECODE_HAZARD_STAGE_BYPASS_EN:
- Defined: a read whose index equals writeRegister (nonzero) while regWriteIn=1 returns writeData in the same cycle (write-through).
- Undefined: the read returns the pre-write stored value.

Verification
REQ-029 SHALL cover: write r5=0x0000_00AA, then decode add r3,r5,r0 -> after 1 clk readRegister0=0xAA, regDst=1, regWriteOut=1, aluOp=1111, outValid=1.
REQ-030 SHALL cover: exMemRead=1, exRt=5, decode add r3,r5,r6 -> stall=1; next clk outValid=0 and controls 0; clearing exMemRead -> stall=0 and the instruction issues.
REQ-031 SHALL cover: exMemRead=1, exRt=5, flush=1 simultaneously -> stall=0, bubble loaded.
REQ-032 SHALL cover: regWriteIn=1, writeRegister=7, writeData=0x1234 while decoding a read of r7 -> readRegister0=0x1234 with DECODE_HAZARD_STAGE_BYPASS_EN defined, the old r7 value without it.
REQ-033 SHALL cover: a write to r0 of 0xFFFF_FFFF, then a read of r0 -> 0; lw imm 0x8004 -> immediateExtended=0xFFFF_8004.
REQ-034 SHALL cover: reset pulsed between clock edges -> outputs 0 immediately, a later read of r5 returns 0.
